cnt162_down: RTL
================

# cnt162_down

Synchronous cascadable down-counter: the decrementing counterpart of the team's CM162 up-count next-state slice. It holds DIGITS 4-bit digits in registers, decrements when both count enables are high, and supports synchronous clear and parallel load. A combinational borrow output chains instances the same way the up-count slice chains its carry (`s`). It is used for reload timers and countdown dividers next to the up-counter logic.

## Interface
- `DIGITS`, default 2: number of 4-bit digits; legal range 1..8.
- `clk` in, 1: rising-edge clock.
- `rst_n` in, 1: asynchronous, active-low reset.
- `clr` in, 1: synchronous clear; highest priority.
- `ld` in, 1: synchronous parallel load; second priority.
- `din` in, 4*DIGITS: load value; digit 0 is in bits [3:0].
- `enp` in, 1: count enable (parallel); gates counting only.
- `ent` in, 1: count enable (trickle); gates counting and also `bo`.
- `q` out, 4*DIGITS: registered count.
- `bo` out, 1: borrow out. Combinational: `ent` AND `q` at the minimum (all zeros).
- `wrap` out, 1: registered one-cycle pulse, high in the cycle after `q` wraps from all zeros.

## Operation
- Per-edge priority: `clr` > `ld` > count (`enp & ent`) > hold.
- `clr`: `q` <= 0 and `wrap` <= 0.
- `ld`: `q` <= `din` after per-digit legalisation (see Configuration). `wrap` <= 0.
- Count step:
  - Digit 0 always decrements.
  - Digit k decrements only when every lower digit was 0 before the edge (internal borrow chain).
  - A digit at 0 reloads to its maximum (9 or 15) when it is borrowed from.
  - When all digits are 0, the whole counter wraps to all-maximum and `wrap` <= 1 for one cycle.
- Hold: `q` unchanged, `wrap` <= 0.
- `bo` is independent of `enp`, so a borrow ripples through a cascade even while `enp` is low.
  - Cascade rule: feed the upstream `bo` to the downstream `ent`, and tie all `enp` inputs together.
- `clr` or `ld` in the same cycle as a wrap condition suppresses the wrap: no `wrap` pulse.
- All arithmetic is modulo per digit. There is no carry/borrow into the counter beyond `ent`.

## Timing
- Reset values (asynchronous, on `rst_n` low): `q` = 0, `wrap` = 0.
  - `bo` then equals `ent`, because `q` is 0.
- Latency: `clr`, `ld` and count are visible on `q` one clock after the sampling edge.
- `wrap` is high for exactly one cycle, coincident with `q` showing the wrapped value.
- `bo` has zero cycles of latency from `ent` and `q`. It is purely combinational and carries no register.
- Reset deassertion is synchronised externally. The block is required only to hold its reset values until the first edge after deassertion.
- Reset asserted mid-count drops `q` to 0 immediately. No `wrap` pulse is generated.

## Configuration
- `CNT162_DOWN_DECADE_EN`:
  - Defined: every digit is BCD (maximum 9). A borrowed-from 0 reloads to 9. A loaded digit greater than 9 saturates to 9.
  - Undefined: every digit is binary (maximum 15), and loaded values pass through unchanged.
  - `bo` and `wrap` semantics are identical in both modes; only the per-digit maximum changes.

## Test plan
- Reset and load:
  - Stimulus: assert `rst_n` low mid-count, then release. Then, with DIGITS=2 and decade mode, `ld`=1 and `din`=0x42.
  - Required: `q`=0x00 immediately on reset, `wrap`=0, `bo`=`ent`. After the load edge, `q`=0x42.
- Count and wrap (decade):
  - Stimulus: load 0x01, hold `enp`=`ent`=1 for 3 edges.
  - Required: `q` goes 0x00 then 0x99 then 0x98. `bo`=1 only while `q`=0x00. `wrap`=1 only in the 0x99 cycle.
- Count and wrap (binary, macro undefined):
  - Stimulus: load 0x10, count 2 edges.
  - Required: `q` goes 0x0F then 0x0E. From 0x00, one further count gives 0xFF with a `wrap` pulse.
- Load saturation (decade):
  - Stimulus: `din`=0xFA.
  - Required: `q`=0x99.
- Enable gating:
  - Stimulus: `q`=0x00 with `enp`=0, `ent`=1 for 2 edges.
  - Required: `q` holds 0x00, `bo`=1, `wrap`=0.
  - Stimulus: then `ent`=0.
  - Required: `bo`=0.
- Priority collision:
  - Stimulus: `q`=0x00, with `clr`, `ld` (`din`=0x37) and count all asserted on one edge.
  - Required: `q`=0x00, `wrap`=0.
  - Stimulus: next edge with `ld` and count only.
  - Required: `q`=0x37, `wrap`=0.

Source files
------------

// File: rtl/cnt162_down.sv
// ----------------------------------------------------------------------------
// cnt162_down
//   Synchronous cascadable down-counter of DIGITS 4-bit digits. It is the
//   decrementing partner of the CM162 up-count slice. It supports
//   synchronous clear, synchronous parallel load and enable-gated counting.
//   A combinational borrow output (bo) chains instances together.
//
// Configuration macro:
//   CNT162_DOWN_DECADE_EN
//     defined   : BCD digits (max 9); loaded digits above 9 saturate to 9.
//     undefined : binary digits (max 15); loaded values pass through as-is.
//
// Ports:
//   clk   in   rising-edge clock
//   rst_n in   asynchronous active-low reset (q = 0, wrap = 0)
//   clr   in   synchronous clear, highest priority
//   ld    in   synchronous parallel load, second priority
//   din   in   load value, 4*DIGITS bits, digit 0 in [3:0]
//   enp   in   parallel count enable (gates counting only)
//   ent   in   trickle count enable (gates counting and bo)
//   q     out  registered count
//   bo    out  combinational borrow: ent & (q == 0)
//   wrap  out  one-cycle pulse, coincident with q showing the wrapped value
// ----------------------------------------------------------------------------
module cnt162_down #(
   parameter int DIGITS = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic                  ld,
   input  logic [4*DIGITS-1:0]   din,
   input  logic                  enp,
   input  logic                  ent,
   output logic [4*DIGITS-1:0]   q,
   output logic                  bo,
   output logic                  wrap
);

   localparam int W = 4 * DIGITS;

`ifdef CNT162_DOWN_DECADE_EN
   localparam logic [3:0] DMAX = 4'd9;
`else
   localparam logic [3:0] DMAX = 4'd15;
`endif

   // Per-digit load legalisation.
   function automatic logic [3:0] sat_digit(input logic [3:0] d);
`ifdef CNT162_DOWN_DECADE_EN
      return (d > DMAX) ? DMAX : d;
`else
      return d;
`endif
   endfunction

   logic [W-1:0] cnt_p1;
   logic         wrap_p1;

   logic [W-1:0] dec_p0;
   logic [W-1:0] ld_p0;
   logic         borrow_p0;
   logic         all_zero_p0;
   logic         cnt_en_p0;

   // Stage p0: combinational next-value candidates from the current count.
   always_comb begin
      dec_p0    = cnt_p1;
      ld_p0     = '0;
      borrow_p0 = 1'b1;
      for (int k = 0; k < DIGITS; k++) begin
         ld_p0[4*k +: 4] = sat_digit(din[4*k +: 4]);
         // A digit moves only when every lower digit was zero.
         if (borrow_p0) begin
            dec_p0[4*k +: 4] = (cnt_p1[4*k +: 4] == 4'd0) ? DMAX
                                                         : cnt_p1[4*k +: 4] - 4'd1;
         end
         borrow_p0 = borrow_p0 & (cnt_p1[4*k +: 4] == 4'd0);
      end
   end

   assign all_zero_p0 = (cnt_p1 == '0);
   assign cnt_en_p0   = enp & ent;

   // Stage p1: registered count and wrap pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_p1  <= '0;
         wrap_p1 <= 1'b0;
      end else if (clr) begin
         cnt_p1  <= '0;
         wrap_p1 <= 1'b0;
      end else if (ld) begin
         cnt_p1  <= ld_p0;
         wrap_p1 <= 1'b0;
      end else if (cnt_en_p0) begin
         cnt_p1  <= dec_p0;
         wrap_p1 <= all_zero_p0;
      end else begin
         wrap_p1 <= 1'b0;
      end
   end

   assign q    = cnt_p1;
   assign wrap = wrap_p1;
   // bo ignores enp so a borrow can ripple through a cascade while paused.
   assign bo   = ent & all_zero_p0;

endmodule
